// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding and default operand width.
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Purpose: single-bit full adder cell.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of inputs.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: WIDTH-bit adder evaluated LSB first through one full_adder cell.
// Latency: done pulses WIDTH+1 cycles after start is sampled; issue interval WIDTH+2.
// Backpressure: start is only honoured in IDLE; requests while busy/done are dropped.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t            state;
    state_t            state_nxt;
    logic              load;
    logic              shift_en;
    logic              last_bit;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_sh;
    logic              carry;
    logic [CNT_W-1:0]  cnt;
    logic              fa_sum;
    logic              fa_carry;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at sum_sh[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (shift_en) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry  <= fa_carry;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign sum  = sum_sh;
    assign cout = carry;

endmodule
